// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port synchronous memory between instruction fetch and data access.
// Data wins contention until fetch has lost STARVE_MAX times in a row; read data returns after LATENCY cycles.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LATENCY    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic [3:0]        dbg_starve_o
);

    typedef enum logic { S_IDLE, S_WAIT } state_e;
    typedef enum logic { OWN_IF, OWN_D } owner_e;

    localparam logic [2:0] CNT_INIT   = 3'(LATENCY);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    // Handshake: a requester holds req (and its address/data) until it sees gnt
    // high in the same cycle; the grant is the acceptance, the rvalid pulse the completion.
    state_e      state_q;
    owner_e      owner_q;
    logic        wr_q;
    logic [2:0]  cnt_q;
    logic [3:0]  starve_q, starve_d;

    logic        grant_ok;
    logic        d_win;
    logic        resp;
    logic [DATA_W-1:0] resp_data;

    always_comb begin
        grant_ok  = (state_q == S_IDLE) && !reset;
        d_win     = d_req && !(if_req && (starve_q == STARVE_LIM));
        d_gnt     = grant_ok && d_win;
        if_gnt    = grant_ok && if_req && !d_win;

        mem_en    = if_gnt || d_gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (d_gnt) begin
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end else if (if_gnt) begin
            mem_addr  = if_addr;
        end

        // The response cycle is the last count of the wait; stores complete with zero data.
        resp      = (state_q == S_WAIT) && (cnt_q == 3'd1) && !reset;
        resp_data = wr_q ? '0 : mem_rdata;
        if_rvalid = resp && (owner_q == OWN_IF);
        d_rvalid  = resp && (owner_q == OWN_D);
        if_rdata  = if_rvalid ? resp_data : '0;
        d_rdata   = d_rvalid ? resp_data : '0;

        starve_d  = starve_q;
        if (if_gnt) begin
            starve_d = '0;
        end else if (d_gnt && if_req && (starve_q < STARVE_LIM)) begin
            starve_d = starve_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            owner_q  <= OWN_IF;
            wr_q     <= 1'b0;
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
            case (state_q)
                S_IDLE: begin
                    if (if_gnt || d_gnt) begin
                        state_q <= S_WAIT;
                        cnt_q   <= CNT_INIT;
                        owner_q <= d_gnt ? OWN_D : OWN_IF;
                        wr_q    <= d_gnt && d_we;
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q - 3'd1;
                    if (cnt_q == 3'd1) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy         = (state_q == S_WAIT);
    assign dbg_starve_o = starve_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: a cycle-level reference model predicts grants,
// memory-port drive and responses; a monitor pops the expected queue on each rvalid.
module tb_mem_port_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int LAT  = 2;
    localparam int SMAX = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req, d_req, d_we;
    logic [AW-1:0] if_addr, d_addr;
    logic [DW-1:0] d_wdata;
    logic          if_gnt, if_rvalid, d_gnt, d_rvalid;
    logic [DW-1:0] if_rdata, d_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          busy;
    logic [3:0]    dbg_starve_o;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(LAT), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .dbg_starve_o(dbg_starve_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- counters / helpers ----------------
    int n_checks = 0;
    int n_err    = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        n_err++;
        $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [DW-1:0] init_word(logic [AW-1:0] a);
        return (a * 32'h9E3779B1) ^ 32'h1234_5678;
    endfunction

    // ---------------- memory model (the device on the port) ----------------
    logic [DW-1:0] mem_arr [logic [AW-1:0]];
    logic [DW-1:0] rd_pipe [LAT];

    assign mem_rdata = rd_pipe[LAT-1];

    always @(posedge clk) begin
        for (int i = LAT - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
        if (mem_en && !mem_we)
            rd_pipe[0] <= mem_arr.exists(mem_addr) ? mem_arr[mem_addr] : init_word(mem_addr);
        else
            rd_pipe[0] <= $urandom;
        if (mem_en && mem_we) mem_arr[mem_addr] = mem_wdata;
    end

    // ---------------- reference model + scoreboard ----------------
    logic [DW:0]   exp_q[$];
    int            due_q[$];
    logic [DW-1:0] ref_mem [logic [AW-1:0]];
    int            cyc    = 0;
    int            free_at = 0;
    int            starve_m = 0;
    int            n_if_gnt = 0;
    int            n_d_gnt  = 0;

    always @(negedge clk) begin
        logic          g_if, g_d;
        logic [DW-1:0] rd;
        logic [DW:0]   e;
        int            due;
        if (reset) begin
            check("rst_if_gnt", if_gnt, 0);
            check("rst_d_gnt", d_gnt, 0);
            check("rst_rvalid", {if_rvalid, d_rvalid}, 0);
            check("rst_rdata", {if_rdata, d_rdata}, 0);
            check("rst_mem", {mem_en, mem_we, mem_addr, mem_wdata}, 0);
            check("rst_busy", busy, 0);
            exp_q.delete();
            due_q.delete();
            free_at  = cyc;
            starve_m = 0;
        end else begin
            if (if_rvalid || d_rvalid) begin
                if (exp_q.size() == 0) begin
                    fail("unexpected_rvalid", {if_rvalid, d_rvalid}, 0);
                end else begin
                    e   = exp_q.pop_front();
                    due = due_q.pop_front();
                    check("rvalid_cycle", cyc, due);
                    check("rvalid_pair", {if_rvalid, d_rvalid}, e[DW] ? 2'b01 : 2'b10);
                    check("rdata", d_rvalid ? d_rdata : if_rdata, e[DW-1:0]);
                end
            end else if (due_q.size() > 0 && due_q[0] <= cyc) begin
                fail("missing_rvalid", cyc, due_q[0]);
                void'(exp_q.pop_front());
                void'(due_q.pop_front());
            end
            if (!if_rvalid) check("if_rdata_idle", if_rdata, 0);
            if (!d_rvalid)  check("d_rdata_idle", d_rdata, 0);
            check("busy", busy, cyc < free_at);
            check("starve", dbg_starve_o, starve_m);

            g_if = 1'b0;
            g_d  = 1'b0;
            if (cyc >= free_at) begin
                if (d_req && !(if_req && starve_m == SMAX)) g_d = 1'b1;
                else if (if_req)                            g_if = 1'b1;
            end
            check("if_gnt", if_gnt, g_if);
            check("d_gnt", d_gnt, g_d);

            if (g_d) begin
                check("mem_port_d", {mem_en, mem_we, mem_addr, mem_wdata}, {1'b1, d_we, d_addr, d_wdata});
                if (d_we) begin
                    ref_mem[d_addr] = d_wdata;
                    rd = '0;
                end else begin
                    rd = ref_mem.exists(d_addr) ? ref_mem[d_addr] : init_word(d_addr);
                end
                exp_q.push_back({1'b1, rd});
                due_q.push_back(cyc + LAT);
                if (if_req && starve_m < SMAX) starve_m++;
                free_at = cyc + LAT + 1;
                n_d_gnt++;
            end else if (g_if) begin
                check("mem_port_if", {mem_en, mem_we, mem_addr, mem_wdata}, {1'b1, 1'b0, if_addr, 32'h0});
                rd = ref_mem.exists(if_addr) ? ref_mem[if_addr] : init_word(if_addr);
                exp_q.push_back({1'b0, rd});
                due_q.push_back(cyc + LAT);
                starve_m = 0;
                free_at  = cyc + LAT + 1;
                n_if_gnt++;
            end else begin
                check("mem_port_idle", {mem_en, mem_we, mem_addr, mem_wdata}, 0);
            end
        end
        cyc++;
    end

    // ---------------- driver ----------------
    int   p_req = 0;
    int   p_wd  = 0;
    logic if_pend = 1'b0, d_pend = 1'b0;
    logic seen_if_gnt, seen_d_gnt;

    function automatic logic [AW-1:0] rand_addr();
        return AW'($urandom_range(0, 15)) << 2;
    endfunction

    task automatic drive_cycle();
        @(negedge clk);
        seen_if_gnt = if_gnt;
        seen_d_gnt  = d_gnt;
        @(posedge clk);
        #1;
        if (seen_if_gnt) if_pend = 1'b0;
        if (seen_d_gnt)  d_pend  = 1'b0;
        if (!if_pend && $urandom_range(0, 99) < p_req) begin
            if_pend = 1'b1;
            if_addr = rand_addr();
        end else if (if_pend && !seen_if_gnt && $urandom_range(0, 99) < p_wd) begin
            if_pend = 1'b0;
        end
        if (!d_pend && $urandom_range(0, 99) < p_req) begin
            d_pend  = 1'b1;
            d_addr  = rand_addr();
            d_we    = $urandom_range(0, 1) == 1;
            d_wdata = $urandom;
        end else if (d_pend && !seen_d_gnt && $urandom_range(0, 99) < p_wd) begin
            d_pend = 1'b0;
        end
        if_req = if_pend;
        d_req  = d_pend;
    endtask

    task automatic run_cycles(int n);
        repeat (n) drive_cycle();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int got;
        reset   = 1'b1;
        if_req  = 1'b0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        if_addr = '0;
        d_addr  = '0;
        d_wdata = '0;
        for (int i = 0; i < LAT; i++) rd_pipe[i] = '0;
        run_cycles(3);
        #1 reset = 1'b0;

        // sparse random traffic with occasional withdrawals
        p_req = 40; p_wd = 5;
        run_cycles(800);

        // both requesters saturated: exercises the starvation rotation
        p_req = 100; p_wd = 0;
        run_cycles(200);

        // reset in the cycle after a data grant drops the transaction
        got = 0;
        for (int i = 0; i < 100 && got == 0; i++) begin
            drive_cycle();
            if (seen_d_gnt) got = 1;
        end
        if (got == 0) fail("reset_setup_no_d_gnt", 0, 1);
        #1 reset = 1'b1;
        #1;
        check("rst_now_busy", busy, 0);
        check("rst_now_mem_en", mem_en, 0);
        check("rst_now_d_rvalid", d_rvalid, 0);
        run_cycles(3);
        #1 reset = 1'b0;

        p_req = 70; p_wd = 3;
        run_cycles(800);

        p_req = 0; p_wd = 0;
        run_cycles(12);
        check("drain_empty", exp_q.size(), 0);
        if (n_if_gnt == 0 || n_d_gnt == 0) fail("grant_coverage", {n_if_gnt, n_d_gnt}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
        $finish;
    end

endmodule
